// File: rtl/video_window_timing.sv
`default_nettype none
// ============================================================================
// Module   : video_window_timing
// Purpose  : Parametrised VGA timing with window-relative fetch coordinates,
//            latency-aligned sync/blank and border/pixel compositing.
// Revision : 1.0 - initial release
// ============================================================================
module video_window_timing #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int COL_MIN    = 208,
    parameter int COL_MAX    = 432,
    parameter int ROW_MIN    = 96,
    parameter int ROW_MAX    = 384,
    parameter int SCALE_LOG2 = 0,
    parameter int PIPE_LAT   = 2,
    parameter int COLOR_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] border_r,
    input  logic [COLOR_W-1:0] border_g,
    input  logic [COLOR_W-1:0] border_b,
    input  logic [COLOR_W-1:0] pix_r,
    input  logic [COLOR_W-1:0] pix_g,
    input  logic [COLOR_W-1:0] pix_b,
    output logic               pix_tick,
    output logic [9:0]         win_col,
    output logic [9:0]         win_row,
    output logic               win_active,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vgaRed,
    output logic [COLOR_W-1:0] vgaGreen,
    output logic [COLOR_W-1:0] vgaBlue,
    output logic               Hsync,
    output logic               Vsync,
    output logic               blank
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] COL_LO = 10'(COL_MIN);
    localparam logic [9:0] COL_HI = 10'(COL_MAX);
    localparam logic [9:0] ROW_LO = 10'(ROW_MIN);
    localparam logic [9:0] ROW_HI = 10'(ROW_MAX);
    // Flag order {hs_n, vs_n, visible, win}
    localparam logic [3:0] FLAGS_IDLE = 4'b1100;

    logic [DIV_W-1:0]   div_q, div_d;
    logic               tick_q, tick_d;
    logic [9:0]         h_q, h_d, v_q, v_d;
    logic               fs_q, fs_d;
    logic               win_q, win_d;
    logic [9:0]         col_q, col_d, row_q, row_d;
    logic [3:0]         w_flags0;
    logic [3:0]         w_dly_out;
    logic               hs_q, vs_q, blank_q;
    logic [COLOR_W-1:0] red_q, grn_q, blu_q;
    logic [COLOR_W-1:0] red_d, grn_d, blu_d;

    // Coordinate-side outputs are computed from next-state counters so they
    // come straight out of flops and line up with h_q/v_q.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_LAST);
        h_d    = h_q;
        v_d    = v_q;
        if (tick_q) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end
        fs_d  = tick_d && (h_d == '0) && (v_d == '0);
        win_d = (h_d >= COL_LO) && (h_d < COL_HI) && (v_d >= ROW_LO) && (v_d < ROW_HI);
        col_d = (h_d - COL_LO) >> SCALE_LOG2;
        row_d = (v_d - ROW_LO) >> SCALE_LOG2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
            fs_q   <= 1'b0;
            win_q  <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
            fs_q   <= fs_d;
            win_q  <= win_d;
            col_q  <= col_d;
            row_q  <= row_d;
        end
    end

    assign w_flags0 = {
        ~((h_q >= HS_BEG) && (h_q < HS_END)),
        ~((v_q >= VS_BEG) && (v_q < VS_END)),
        (h_q < H_VIS) && (v_q < V_VIS),
        win_q
    };

    generate
        if (PIPE_LAT == 0) begin : g_bypass
            assign w_dly_out = w_flags0;
        end else begin : g_delay
            logic [3:0] dly_q [PIPE_LAT];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int i = 0; i < PIPE_LAT; i++) begin
                        dly_q[i] <= FLAGS_IDLE;
                    end
                end else if (tick_q) begin
                    dly_q[0] <= w_flags0;
                    for (int i = 1; i < PIPE_LAT; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end
            assign w_dly_out = dly_q[PIPE_LAT-1];
        end
    endgenerate

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (w_dly_out[1]) begin
            if (w_dly_out[0]) begin
                red_d = pix_r;
                grn_d = pix_g;
                blu_d = pix_b;
            end else begin
                red_d = border_r;
                grn_d = border_g;
                blu_d = border_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b1;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else if (tick_q) begin
            hs_q    <= w_dly_out[3];
            vs_q    <= w_dly_out[2];
            blank_q <= ~w_dly_out[1];
            red_q   <= red_d;
            grn_q   <= grn_d;
            blu_q   <= blu_d;
        end
    end

    assign pix_tick    = tick_q;
    assign frame_start = fs_q;
    assign win_active  = win_q;
    assign win_col     = col_q;
    assign win_row     = row_q;
    assign Hsync       = hs_q;
    assign Vsync       = vs_q;
    assign blank       = blank_q;
    assign vgaRed      = red_q;
    assign vgaGreen    = grn_q;
    assign vgaBlue     = blu_q;

endmodule
`default_nettype wire

// File: doc/video_window_timing.md
Name: video_window_timing

Overview:
- Parametrised successor to the fixed 640x480 VGA controller and frame-window logic.
- Generates VGA timing from a divided system clock.
- Produces window-relative, optionally down-scaled pixel coordinates for the tile/sprite fetch pipeline.
- Realigns sync, blank and window flags to the fetch latency, then composites fetched pixels over a programmable border colour.

Parameters:
CLK_DIV, 4, system clocks per pixel tick (1 = tick every cycle)
H_ACTIVE, 640, visible columns
H_FP, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync width (ticks)
H_BP, 48, horizontal back porch (ticks)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
COL_MIN, 208, first window column (inclusive)
COL_MAX, 432, window column bound (exclusive)
ROW_MIN, 96, first window row (inclusive)
ROW_MAX, 384, window row bound (exclusive)
SCALE_LOG2, 0, window coordinates right-shifted by this amount (pixel replication)
PIPE_LAT, 2, pixel ticks from coordinate output to valid pix_* input (0..8)
COLOR_W, 4, bits per colour channel

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
border_r/g/b  in  COLOR_W each  colour outside the window, inside the visible area
pix_r/g/b  in  COLOR_W each  fetched pixel, valid PIPE_LAT ticks after its coordinates
pix_tick  out  1  one-clk pulse, pixel tick
win_col  out  10  (h-COL_MIN)>>SCALE_LOG2
win_row  out  10  (v-ROW_MIN)>>SCALE_LOG2
win_active  out  1  current (h,v) is inside the window
frame_start  out  1  one-clk pulse when counters reach h=0, v=0
vgaRed/vgaGreen/vgaBlue  out  COLOR_W each  composited video
Hsync, Vsync  out  1  active-low sync, latency-aligned
blank  out  1  outside visible area, latency-aligned

Behaviour:
- Reset (rst=0, asynchronous) state:
  - Divider, h and v counters = 0.
  - pix_tick=0, frame_start=0, win_active=0, win_col=win_row=0.
  - Hsync=Vsync=1, blank=1, colour outputs=0.
  - Whole delay line loaded with inactive values (sync=1, blank=1, win=0).
- Release: first tick occurs CLK_DIV clocks after rst rises.
- Divider: counts 0..CLK_DIV-1 and wraps; pix_tick=1 in the cycle where the count equals CLK_DIV-1. All state below advances only on pix_tick.
- Timing counters:
  - H_TOTAL = sum of H parameters (800); V_TOTAL = sum of V parameters (525); both counters are 10 bits.
  - h increments every tick; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps from V_TOTAL-1 to 0 on the same tick h wraps.
- Stage 0 (registered counters):
  - visible = h<H_ACTIVE && v<V_ACTIVE.
  - hs_n = 0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_n defined likewise on v.
  - win_active = COL_MIN<=h<COL_MAX && ROW_MIN<=v<ROW_MAX (half-open).
- win_col/win_row: unsigned 10-bit subtraction then logical shift. Values outside the window are don't-care, but must be stable and glitch-free.
- frame_start: asserted during the tick cycle where h=0, v=0 is first presented; exactly one clk wide.
- Delay line: PIPE_LAT-deep shift register of {hs_n, vs_n, visible, win_active}, advancing on pix_tick.
- Output register, loaded on pix_tick from the delayed flags:
  - !visible -> colour=0.
  - visible && win -> pix_*.
  - visible && !win -> border_*.
  - Hsync/Vsync/blank loaded from the same delayed flags.
- Total latency: outputs reflect counter state from PIPE_LAT+1 ticks earlier; all outputs change only on tick cycles.
- PIPE_LAT=0: delay line is bypassed and latency is 1 tick.
- border_* and pix_* are sampled only on pix_tick; changes between ticks have no effect.
- Reset mid-frame: immediate return to the reset state; restart from h=0, v=0; no partial sync pulse is held.

Test Plan:
- Reset: hold rst=0 for 10 clks -> Hsync=Vsync=blank=1, colours=0. After release, first pix_tick on clk 4 (CLK_DIV=4) and first frame_start on that same clk.
- Line timing, defaults: Hsync low for exactly 96 ticks (384 clks). Falling edge 656+PIPE_LAT+1=659 ticks after frame_start. Period 800 ticks.
- Frame timing: frame_start spacing = 800*525*4 = 1,680,000 clks. Vsync low for 2 lines (1600 ticks).
- Window edge, v=100: h=207 -> win_active=0, output = border_* 3 ticks later. h=208 -> win_active=1, win_col=0, win_row=4, output = pix_* applied 2 ticks later. h=431 win=1, h=432 win=0.
- SCALE_LOG2=1: h=211, v=101 -> win_col=1, win_row=2. Unique pix value per tick appears on vgaRed exactly PIPE_LAT+1 ticks later.
- Reset mid-line at h=300: outputs return to reset values within the same clk. Counters restart at 0; next frame_start on the first tick after release.
